// File: rtl/cond_unit_pipe_if.sv
// E-stage control bundle between the pipeline and the conditional unit.
// The master side drives the E-stage instruction controls; the slave side is the
// conditional unit, which returns the condition result, flags and M-stage controls.
interface cond_unit_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  // Pipeline to conditional unit
  logic             en;
  logic             flush_e;
  logic [3:0]       cond_e;
  logic [3:0]       alu_flags_e;
  logic [1:0]       flag_write_e;
  logic             reg_write_e;
  logic             mem_write_e;
  logic             pc_s_e;
  logic             branch_e;

  // Conditional unit to pipeline
  logic             cond_ex_e;
  logic             branch_taken_e;
  logic [3:0]       flags;
  logic             reg_write_m;
  logic             mem_write_m;
  logic             pc_src_m;
  logic [CNT_W-1:0] annul_cnt;

  modport master (
    output en, flush_e, cond_e, alu_flags_e, flag_write_e,
    output reg_write_e, mem_write_e, pc_s_e, branch_e,
    input  cond_ex_e, branch_taken_e, flags,
    input  reg_write_m, mem_write_m, pc_src_m, annul_cnt
  );

  modport slave (
    input  en, flush_e, cond_e, alu_flags_e, flag_write_e,
    input  reg_write_e, mem_write_e, pc_s_e, branch_e,
    output cond_ex_e, branch_taken_e, flags,
    output reg_write_m, mem_write_m, pc_src_m, annul_cnt
  );
endinterface

// File: rtl/cond_unit_pipe.sv
// Execute-stage conditional unit. Holds the architectural NZCV flags, evaluates
// the E-stage condition field against them, gates the write/branch controls and
// registers the gated controls into M. Also counts annulled instructions.
module cond_unit_pipe #(
  parameter int unsigned CNT_W = 16
) (
  input logic              i_clk,
  input logic              i_reset,
  cond_unit_pipe_if.slave  bus
);

  // Architectural state and M-stage pipeline registers
  logic [3:0]       r_flags;
  logic             r_reg_write_m;
  logic             r_mem_write_m;
  logic             r_pc_src_m;
  logic [CNT_W-1:0] r_annul_cnt;

  // Next-state values
  logic [3:0]       w_flags_nxt;
  logic             w_reg_write_nxt;
  logic             w_mem_write_nxt;
  logic             w_pc_src_nxt;
  logic [CNT_W-1:0] w_annul_cnt_nxt;

  // Decoded flag bits and condition result
  logic w_n, w_z, w_c, w_v;
  logic w_ge;
  logic w_cond_ex;
  logic w_ex;
  logic w_annul;
  logic w_cnt_max;

  assign w_n  = r_flags[3];
  assign w_z  = r_flags[2];
  assign w_c  = r_flags[1];
  assign w_v  = r_flags[0];
  assign w_ge = (w_n == w_v);

  // Condition decode against the registered flags; the instruction's own ALU
  // flags are never visible here, only those written by older instructions.
  always_comb begin
    w_cond_ex = 1'b0;
    case (bus.cond_e)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~(w_c & ~w_z);
      4'b1010: w_cond_ex = w_ge;
      4'b1011: w_cond_ex = ~w_ge;
      4'b1100: w_cond_ex = ~w_z & w_ge;
      4'b1101: w_cond_ex = ~(~w_z & w_ge);
      4'b1110: w_cond_ex = 1'b1;
      default: w_cond_ex = 1'b0;  // 1111 is reserved and never executes
    endcase
  end

  assign w_ex      = w_cond_ex & ~bus.flush_e;
  // Bubbles are not annulled instructions, whatever their condition field holds
  assign w_annul   = ~bus.flush_e & ~w_cond_ex;
  assign w_cnt_max = &r_annul_cnt;

  // Next-state for flags (halves update independently), M controls and counter
  always_comb begin
    w_flags_nxt     = r_flags;
    w_reg_write_nxt = bus.reg_write_e & w_ex;
    w_mem_write_nxt = bus.mem_write_e & w_ex;
    w_pc_src_nxt    = (bus.pc_s_e | bus.branch_e) & w_ex;
    w_annul_cnt_nxt = r_annul_cnt;

    if (bus.flag_write_e[1] && w_ex) begin
      w_flags_nxt[3:2] = bus.alu_flags_e[3:2];
    end
    if (bus.flag_write_e[0] && w_ex) begin
      w_flags_nxt[1:0] = bus.alu_flags_e[1:0];
    end
    if (w_annul && !w_cnt_max) begin
      w_annul_cnt_nxt = r_annul_cnt + CNT_W'(1);
    end
  end

  // State registers: reset beats hold, hold beats everything else
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flags       <= 4'b0000;
      r_reg_write_m <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_pc_src_m    <= 1'b0;
      r_annul_cnt   <= '0;
    end else if (bus.en) begin
      r_flags       <= w_flags_nxt;
      r_reg_write_m <= w_reg_write_nxt;
      r_mem_write_m <= w_mem_write_nxt;
      r_pc_src_m    <= w_pc_src_nxt;
      r_annul_cnt   <= w_annul_cnt_nxt;
    end
  end

  assign bus.cond_ex_e      = w_cond_ex;
  // Drives the F/D flush, so it must not wait for the M register
  assign bus.branch_taken_e = (bus.branch_e | bus.pc_s_e) & w_ex;
  assign bus.flags          = r_flags;
  assign bus.reg_write_m    = r_reg_write_m;
  assign bus.mem_write_m    = r_mem_write_m;
  assign bus.pc_src_m       = r_pc_src_m;
  assign bus.annul_cnt      = r_annul_cnt;

endmodule

// File: doc/cond_unit_pipe.md
Name: cond_unit_pipe

Overview:
- Execute-stage conditional unit for the pipelined ARM core.
- Owns the architectural NZCV flag register. Evaluates the E-stage instruction's 4-bit condition field against the current flags.
- Gates register-write, memory-write, PC-write and branch controls.
- Registers the gated controls into the Memory stage and keeps a saturating count of annulled (condition-failed) instructions for debug.

Parameters:
- CNT_W, 16, width of the annulled-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance for E→M; 0 = hold all state.
- flush_e  in  1  the instruction in E is a bubble.
- cond_e  in  4  condition field of the E-stage instruction.
- alu_flags_e  in  4  {N,Z,C,V} from the ALU for the E-stage instruction.
- flag_write_e  in  2  bit1 = write N,Z; bit0 = write C,V.
- reg_write_e  in  1  ungated register-file write.
- mem_write_e  in  1  ungated memory write.
- pc_s_e  in  1  ungated PC write (destination R15).
- branch_e  in  1  instruction is B/BL.
- cond_ex_e  out  1  condition passes (combinational).
- branch_taken_e  out  1  (branch_e | pc_s_e) & cond_ex_e & ~flush_e (combinational, drives F/D flush).
- flags  out  4  current architectural {N,Z,C,V}.
- reg_write_m  out  1  gated register write, M stage.
- mem_write_m  out  1  gated memory write, M stage.
- pc_src_m  out  1  gated PC write or branch, M stage.
- annul_cnt  out  CNT_W  count of non-bubble instructions whose condition failed.

Behaviour:
- Reset (reset=1 at clk edge): flags=0000, reg_write_m=mem_write_m=pc_src_m=0, annul_cnt=0. Reset overrides en and flush_e.
- Condition evaluation uses the registered flags, with ge=(N==V):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~(C&~Z).
  - 1010 GE ge; 1011 LT ~ge; 1100 GT ~Z&ge; 1101 LE ~(~Z&ge).
  - 1110 AL 1; 1111 is decided as 0, never X.
- Effective execute: ex = cond_ex_e & ~flush_e.
- Flag update at the edge when en=1:
  - flags[3:2] ← alu_flags_e[3:2] if flag_write_e[1] & ex.
  - flags[1:0] ← alu_flags_e[1:0] if flag_write_e[0] & ex.
  - Otherwise the halves hold independently.
- Flag visibility:
  - An instruction sees only flags written by older instructions. The update lands at the end of its E cycle, so the next E-stage instruction sees it with no bypass needed.
  - An instruction never sees its own ALU flags.
- E→M registers, latency 1, when en=1:
  - reg_write_m ← reg_write_e & ex.
  - mem_write_m ← mem_write_e & ex.
  - pc_src_m ← (pc_s_e | branch_e) & ex.
- Flush: flush_e=1 with en=1 loads zeros into M regs, writes no flags and does not count. A flushed instruction never counts as annulled, whatever cond_e is.
- Hold: en=0 holds flags, M regs and annul_cnt, regardless of flush_e and other inputs. Combinational outputs still track inputs.
- Annul counter: when en=1, annul_cnt increments if ~flush_e & ~cond_ex_e. It saturates at 2^CNT_W−1 and never wraps.
- Priority: reset > ~en (hold) > flush_e > normal.
- No internal FSM beyond the flag, M-stage and counter registers. All outputs are defined from the first post-reset cycle.

Test Plan:
- Reset then ADDS with alu_flags_e=0100, flag_write_e=11, cond_e=1110 → next cycle flags=0100; following cond_e=0000 gives cond_ex_e=1; reg_write_e=1 → reg_write_m=1 one cycle later.
- flags=0100, cond_e=0001 (NE), reg_write_e=1, mem_write_e=1, flag_write_e=11, alu_flags_e=1000 → cond_ex_e=0, reg_write_m=mem_write_m=0, flags stay 0100, annul_cnt=1.
- flags=1000, flag_write_e=01, alu_flags_e=0111, AL → flags=1011 (NZ preserved, CV updated); then cond_e=1010 (GE) → cond_ex_e=1 (N=1,V=1).
- branch_e=1, cond_e=1110, flush_e=1 → branch_taken_e=0, pc_src_m=0, annul_cnt unchanged. Same with flush_e=0 → branch_taken_e=1, pc_src_m=1 next cycle.
- en=0 for 3 cycles with reg_write_e=1, flag_write_e=11, alu_flags_e=1111 → flags, reg_write_m and annul_cnt unchanged. Assert reset during the hold → all registered outputs 0 at the next edge.
- CNT_W=2: 5 consecutive condition-failed instructions (cond_e=1111) → annul_cnt 1,2,3,3,3 (saturates).
